// File: rtl/pe_edge_drain.sv
// pe_edge_drain: removes the column skew from the systolic array's bottom-edge
// result streams, packs each row into one word and queues it in a FWFT FIFO.
// Ports: clk, reset (async, active-high); drain_start/drain_ready accept a drain;
//   drain_done pulses once the last row is queued; edge_data carries the
//   bottom-edge PE outputs; out_data/out_valid/out_ready form the row stream;
//   fifo_count is the FIFO occupancy.
// Optional macro DRAIN_ROW_TAG_EN adds out_row_idx (row index of the FIFO head).
module pe_edge_drain #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_COLS   = 4,
   parameter int ROWS       = 4,
   parameter int DEPTH      = 8,
   localparam int CNTW      = $clog2(DEPTH) + 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           drain_start,
   output logic                           drain_ready,
   output logic                           drain_done,
   input  logic [NUM_COLS*DATA_WIDTH-1:0] edge_data,
   output logic [NUM_COLS*DATA_WIDTH-1:0] out_data,
`ifdef DRAIN_ROW_TAG_EN
   output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row_idx,
`endif
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [CNTW-1:0]                fifo_count
);

   localparam int W  = NUM_COLS * DATA_WIDTH;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(NUM_COLS + ROWS);
   localparam logic [CW-1:0]   FIRST = CW'(NUM_COLS - 1);
   localparam logic [CW-1:0]   LAST  = CW'(NUM_COLS + ROWS - 2);
   localparam logic [CNTW-1:0] ROOM  = CNTW'(DEPTH - ROWS);

   typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            shift;
   logic            push;
   logic            pop;
   logic            accept;
   logic            idle_n;
   logic [W-1:0]    aligned;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CNTW-1:0] count_n;
   logic [W-1:0]    mem [DEPTH];

   assign shift     = (state == CAPTURE);
   // first aligned row exists once column 0 has walked its whole chain
   assign push      = shift && (cnt >= FIRST);
   assign out_valid = (fifo_count != '0);
   assign pop       = out_valid && out_ready;
   assign accept    = drain_start && drain_ready;
   assign idle_n    = (state == DONE) || ((state == IDLE) && !accept);

   // column c is NUM_COLS-1-c cycles early, so it waits that many stages
   for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      localparam int D = NUM_COLS - 1 - c;
      if (D == 0) begin : g_live
         assign aligned[c*DATA_WIDTH +: DATA_WIDTH] =
            edge_data[c*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_dly
         logic [DATA_WIDTH-1:0] sr [D];
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < D; i++) sr[i] <= '0;
            end else if (shift) begin
               sr[0] <= edge_data[c*DATA_WIDTH +: DATA_WIDTH];
               for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
            end
         end
         assign aligned[c*DATA_WIDTH +: DATA_WIDTH] = sr[D-1];
      end
   end

   always_comb begin
      count_n = fifo_count;
      case ({push, pop})
         2'b10:   count_n = fifo_count + CNTW'(1);
         2'b01:   count_n = fifo_count - CNTW'(1);
         default: count_n = fifo_count;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         drain_done  <= 1'b0;
         drain_ready <= 1'b0;
      end else begin
         drain_done  <= 1'b0;
         // ready is registered from next state so it is low throughout reset
         drain_ready <= idle_n && (count_n <= ROOM);
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= CAPTURE;
                  cnt   <= '0;
               end
            end
            CAPTURE: begin
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  state      <= DONE;
                  drain_done <= 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         fifo_count <= count_n;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= aligned;
   end

   assign out_data = out_valid ? mem[rd_ptr] : '0;

`ifdef DRAIN_ROW_TAG_EN
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   logic [RW-1:0] tag_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_ptr] <= RW'(cnt - FIRST);
   end

   assign out_row_idx = out_valid ? tag_mem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_pe_edge_drain.sv
// tb_pe_edge_drain: directed table plus sequences for pe_edge_drain.
// Compares outputs against hand-computed rows and a small FIFO model.
module tb_pe_edge_drain;
   localparam int DW    = 8;
   localparam int NC    = 4;
   localparam int ROWS  = 4;
   localparam int DEPTH = 8;
   localparam int LASTK = NC + ROWS;

   logic          clk = 1'b0;
   logic          reset;
   logic          drain_start;
   logic          drain_ready;
   logic          drain_done;
   logic [31:0]   edge_data;
   logic [31:0]   out_data;
   logic          out_valid;
   logic          out_ready;
   logic [3:0]    fifo_count;
`ifdef DRAIN_ROW_TAG_EN
   logic [1:0]    out_row_idx;
`endif

   int checks   = 0;
   int failures = 0;
   logic [31:0] q[$];
   int          tq[$];

   typedef struct {
      bit          start;
      int          k;
      bit          vld;
      logic [31:0] data;
      bit          done;
      bit          drdy;
      int          cnt;
      int          tag;
   } vec_t;
   vec_t tbl[10];

   always #5 clk = ~clk;

   pe_edge_drain #(
      .DATA_WIDTH(DW), .NUM_COLS(NC), .ROWS(ROWS), .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .drain_start(drain_start),
      .drain_ready(drain_ready),
      .drain_done(drain_done),
      .edge_data(edge_data),
      .out_data(out_data),
`ifdef DRAIN_ROW_TAG_EN
      .out_row_idx(out_row_idx),
`endif
      .out_valid(out_valid),
      .out_ready(out_ready),
      .fifo_count(fifo_count)
   );

   function automatic logic [31:0] edge_word(int k, logic [7:0] base);
      logic [31:0] w;
      int r;
      w = '0;
      for (int c = 0; c < NC; c++) begin
         r = k - 1 - c;
         if (r >= 0 && r < ROWS) w[c*DW +: DW] = base + 8'(16*r + c);
         else                    w[c*DW +: DW] = 8'hEE;
      end
      return w;
   endfunction

   function automatic logic [31:0] row_word(logic [7:0] base, int r);
      logic [31:0] w;
      w = '0;
      for (int c = 0; c < NC; c++) w[c*DW +: DW] = base + 8'(16*r + c);
      return w;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input bit exp_done,
                                input bit idle);
      chk({tag, "_count"}, 64'(fifo_count), 64'(q.size()));
      chk({tag, "_valid"}, 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
         chk({tag, "_data"}, 64'(out_data), 64'(q[0]));
`ifdef DRAIN_ROW_TAG_EN
         chk({tag, "_rowidx"}, 64'(out_row_idx), 64'(tq[0]));
`endif
      end
      chk({tag, "_done"}, 64'(drain_done), 64'(exp_done));
      chk({tag, "_ready"}, 64'(drain_ready),
          64'(idle && (DEPTH - q.size() >= ROWS)));
   endtask

   task automatic idle_step(input bit st, input bit rdy);
      bit p;
      drain_start = st;
      out_ready   = rdy;
      edge_data   = 32'hEEEE_EEEE;
      p = rdy && (q.size() != 0);
      @(posedge clk); #1;
      if (p) begin
         void'(q.pop_front());
         void'(tq.pop_front());
      end
      check_outputs("idle", 1'b0, 1'b1);
   endtask

   // one drain accepted at the first edge; out_ready rises at step rdy_from
   task automatic do_drain(input logic [7:0] base, input bit hold,
                           input int rdy_from);
      bit p;
      for (int k = 0; k <= LASTK; k++) begin
         drain_start = (k == 0) || hold;
         out_ready   = (k >= rdy_from);
         edge_data   = edge_word(k, base);
         if (k == 0) chk("accept_ready", 64'(drain_ready), 64'(1));
         p = out_ready && (q.size() != 0);
         @(posedge clk); #1;
         if (p) begin
            void'(q.pop_front());
            void'(tq.pop_front());
         end
         if (k >= NC && k < NC + ROWS) begin
            q.push_back(row_word(base, k - NC));
            tq.push_back(k - NC);
         end
         check_outputs($sformatf("drain%0h_k%0d", base, k),
                       k == LASTK - 1, k == LASTK);
      end
   endtask

   initial begin
      tbl[0] = '{1'b1, 0, 1'b0, 32'h0,         1'b0, 1'b0, 0, 0};
      tbl[1] = '{1'b0, 1, 1'b0, 32'h0,         1'b0, 1'b0, 0, 0};
      tbl[2] = '{1'b0, 2, 1'b0, 32'h0,         1'b0, 1'b0, 0, 0};
      tbl[3] = '{1'b0, 3, 1'b0, 32'h0,         1'b0, 1'b0, 0, 0};
      tbl[4] = '{1'b0, 4, 1'b1, 32'h0302_0100, 1'b0, 1'b0, 1, 0};
      tbl[5] = '{1'b0, 5, 1'b1, 32'h1312_1110, 1'b0, 1'b0, 1, 1};
      tbl[6] = '{1'b0, 6, 1'b1, 32'h2322_2120, 1'b0, 1'b0, 1, 2};
      tbl[7] = '{1'b0, 7, 1'b1, 32'h3332_3130, 1'b1, 1'b0, 1, 3};
      tbl[8] = '{1'b0, 8, 1'b0, 32'h0,         1'b0, 1'b1, 0, 0};
      tbl[9] = '{1'b0, 9, 1'b0, 32'h0,         1'b0, 1'b1, 0, 0};

      reset       = 1'b1;
      drain_start = 1'b0;
      out_ready   = 1'b0;
      edge_data   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 64'(drain_ready), 64'(0));
      chk("rst_done",  64'(drain_done),  64'(0));
      chk("rst_valid", 64'(out_valid),   64'(0));
      chk("rst_count", 64'(fifo_count),  64'(0));
      chk("rst_data",  64'(out_data),    64'(0));
      reset = 1'b0;
      idle_step(1'b0, 1'b1);

      // basic drain, out_ready held high
      for (int i = 0; i < 10; i++) begin
         drain_start = tbl[i].start;
         out_ready   = 1'b1;
         edge_data   = edge_word(tbl[i].k, 8'h00);
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].vld));
         chk($sformatf("tbl%0d_count", i), 64'(fifo_count), 64'(tbl[i].cnt));
         chk($sformatf("tbl%0d_done", i), 64'(drain_done), 64'(tbl[i].done));
         chk($sformatf("tbl%0d_ready", i), 64'(drain_ready), 64'(tbl[i].drdy));
         if (tbl[i].vld) begin
            chk($sformatf("tbl%0d_data", i), 64'(out_data), 64'(tbl[i].data));
`ifdef DRAIN_ROW_TAG_EN
            chk($sformatf("tbl%0d_rowidx", i), 64'(out_row_idx),
                64'(tbl[i].tag));
`endif
         end
      end

      // backpressure: two drains fill the FIFO, head holds
      do_drain(8'h00, 1'b0, 99);
      do_drain(8'h40, 1'b0, 99);
      chk("bp_full_count", 64'(fifo_count), 64'(8));
      chk("bp_full_ready", 64'(drain_ready), 64'(0));
      chk("bp_head", 64'(out_data), 64'(32'h0302_0100));
      idle_step(1'b1, 1'b0);
      idle_step(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) idle_step(1'b0, 1'b1);
      chk("bp_pop3_ready", 64'(drain_ready), 64'(0));
      chk("bp_pop3_head", 64'(out_data), 64'(32'h3332_3130));
      idle_step(1'b0, 1'b1);
      chk("bp_pop4_ready", 64'(drain_ready), 64'(1));
      chk("bp_pop4_head", 64'(out_data), 64'(32'h4342_4140));
      for (int i = 0; i < 5; i++) idle_step(1'b0, 1'b1);

      // start held high through CAPTURE and DONE
      do_drain(8'h80, 1'b1, 0);
      do_drain(8'hC0, 1'b1, 0);
      for (int i = 0; i < 4; i++) idle_step(1'b0, 1'b1);

      // simultaneous push and pop with two entries queued
      do_drain(8'h20, 1'b0, 6);
      for (int i = 0; i < 2; i++) idle_step(1'b0, 1'b1);

      // reset in the middle of a drain
      for (int k = 0; k <= 5; k++) begin
         drain_start = (k == 0);
         out_ready   = 1'b0;
         edge_data   = edge_word(k, 8'h08);
         if (k == 0) chk("mid_accept", 64'(drain_ready), 64'(1));
         @(posedge clk); #1;
      end
      chk("mid_pre_count", 64'(fifo_count), 64'(2));
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(out_valid),   64'(0));
      chk("mid_rst_count", 64'(fifo_count),  64'(0));
      chk("mid_rst_ready", 64'(drain_ready), 64'(0));
      chk("mid_rst_done",  64'(drain_done),  64'(0));
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_hold_done", 64'(drain_done), 64'(0));
      reset = 1'b0;
      q.delete();
      tq.delete();
      for (int i = 0; i < 6; i++) idle_step(1'b0, 1'b1);
      do_drain(8'h08, 1'b0, 0);
      for (int i = 0; i < 2; i++) idle_step(1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
